rob_queue: RTL and testbench
============================

# rob_queue

Parametrised reorder buffer for the out-of-order core, generalising the core's fixed in-line ROB. It accepts one in-order dispatch per cycle, NUM_WB out-of-order writebacks per cycle, and one in-order commit per cycle under a ready/valid handshake. It adds two capabilities: a precise partial squash (discard everything younger than a given tag), and full flush on a mispredicted branch at commit. It sits between decode/rename (dispatch), the execute units (writeback) and the register file / PC redirect logic (commit).

## Interface
- DEPTH, 8, entries; power of two, ≥2; TAG_W = log2(DEPTH)
- PC_W, 4, PC width
- DATA_W, 8, result data width
- RF_LOG, 2, destination register index width
- NUM_WB, 2, writeback ports
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- disp_valid / disp_ready  in / out  1  dispatch handshake
- disp_pc, disp_wen, disp_rd, disp_is_br, disp_pred_taken  in  PC_W,1,RF_LOG,1,1  entry payload
- disp_tag  out  TAG_W  slot the current dispatch will occupy (tail index)
- wb_valid  in  NUM_WB  per-port writeback strobe
- wb_tag, wb_data, wb_taken, wb_next_pc  in  NUM_WB×{TAG_W,DATA_W,1,PC_W}  flattened, port 0 in LSBs
- cm_valid / cm_ready  out / in  1  commit handshake
- cm_tag, cm_pc, cm_wen, cm_rd, cm_data, cm_next_pc  out  head entry fields
- cm_squash  out  1  head is a branch with pred_taken ≠ taken
- sq_valid, sq_tag  in  1, TAG_W  partial squash request
- count  out  TAG_W+1  live entries

## Operation
- Per-entry state: IDLE → PENDING (dispatch) → DONE (writeback) → IDLE (commit/squash).
- Pointers head/tail are TAG_W+1 bits with a wrap bit. Full = count==DEPTH. Empty = count==0.
- disp_ready = !full && !sq_valid && !(cm_valid && cm_squash). A dispatch fires when disp_valid && disp_ready: the entry is written at tail[TAG_W-1:0] and tail increments.
- Writeback: a port with wb_valid whose tag addresses a PENDING entry stores data/taken/next_pc and moves the entry to DONE. A writeback to an IDLE or DONE entry is ignored. If two ports hit the same tag, the lowest-numbered port wins.
- cm_valid = head entry DONE. A commit fires when cm_valid && cm_ready: the head entry goes IDLE and head increments.
- Commit fire with cm_squash=1: every entry goes IDLE and tail := head+1, leaving the ROB empty. In-flight writebacks that cycle are discarded.
- sq_valid: if sq_tag addresses a live entry, all entries strictly younger than it go IDLE and tail := sq_tag-entry position+1. If sq_tag does not address a live entry, the request is ignored. Writebacks to squashed tags that same cycle are discarded.
- Commit and sq_valid may fire together. Commit is applied first. If sq_tag==head, the result is an empty ROB.
- Precedence: rst > commit-squash > sq_valid > normal dispatch/writeback/commit.

## Timing
- Reset values: head=tail=0, all entries IDLE, count=0, disp_ready=1, cm_valid=0, cm_squash=0, disp_tag=0. Other cm_* fields are don't-care while cm_valid=0.
- Dispatch-to-writeback eligibility: a tag may be written back from the cycle after its dispatch.
- Writeback-to-commit: at least 1 cycle. There is no same-cycle bypass; cm_valid rises the cycle after the head's writeback.
- Dispatch and commit in the same cycle when full: commit frees a slot only for the next cycle (disp_ready is computed from the registered count).
- Throughput: 1 dispatch + NUM_WB writebacks + 1 commit per cycle sustained.
- Wrap-around is exercised every DEPTH dispatches. The wrap bit distinguishes full from empty.
- rst asserted mid-operation clears state immediately (asynchronous). Outputs take their reset values without waiting for a clock edge.

## Structure
- Shared package: entry state encoding (IDLE/PENDING/DONE), TAG_W derivation function, and the default widths shared with the core.
- One sub-module, rob_wb_arbiter: a per-entry priority match of the NUM_WB ports, producing hit/port-select for each entry. Everything else (pointers, entry array, commit mux) stays in rob_queue.

## Test plan
- Fill with DEPTH=8 dispatches while cm_ready=0 → disp_ready=0 and count=8. The 9th dispatch is not accepted. Then write back all tags and set cm_ready=1 → 8 commits in tag order 0..7.
- Write back tags 3,1,2,0 out of order on ports 1/0 → commits emerge in tags 0,1,2,3. Each commit occurs ≥1 cycle after its writeback.
- Branch at tag 2 with pred_taken=0, wb_taken=1, wb_next_pc=9 → at commit cm_squash=1 and cm_next_pc=9. The next cycle count=0 and the tags 3..5 that were live are gone. A dispatch in the squash cycle is refused.
- 6 live entries at head=0, sq_tag=2 → count=3 next cycle and the next disp_tag=3. A wb to tag 4 in the same cycle is ignored.
- Run 20 dispatch/commit pairs → tags wrap 7→0 with correct ordering. Assert rst mid-stream → count=0 and cm_valid=0 immediately, without a clock edge.

Source files
------------

// File: rtl/rob_queue_pkg.sv
// Shared definitions for the reorder buffer: entry state encoding, default
// widths shared with the core, and tag/select width helpers.
package rob_queue_pkg;

  typedef logic [1:0] rob_state_t;

  localparam rob_state_t ST_IDLE    = 2'd0;
  localparam rob_state_t ST_PENDING = 2'd1;
  localparam rob_state_t ST_DONE    = 2'd2;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_PC_W   = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_RF_LOG = 2;
  localparam int DEF_NUM_WB = 2;

  function automatic int rob_tag_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int rob_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rob_wb_arbiter.sv
// Per-entry tag match across the writeback ports; when several ports hit the
// same entry the lowest-numbered port is selected.
module rob_wb_arbiter
  import rob_queue_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_WB = DEF_NUM_WB,
  parameter int TAG_W  = rob_tag_w(DEPTH),
  parameter int SEL_W  = rob_sel_w(NUM_WB)
) (
  input  logic [NUM_WB-1:0]       i_wb_valid,
  input  logic [NUM_WB*TAG_W-1:0] i_wb_tag,
  output logic [DEPTH-1:0]        o_hit,
  output logic [DEPTH*SEL_W-1:0]  o_sel
);

  always_comb begin
    o_hit = '0;
    o_sel = '0;
    for (int e = 0; e < DEPTH; e++) begin
      // Scan high to low so the lowest matching port is written last.
      for (int p = NUM_WB - 1; p >= 0; p--) begin
        if (i_wb_valid[p] && (i_wb_tag[p*TAG_W +: TAG_W] == TAG_W'(e))) begin
          o_hit[e]                = 1'b1;
          o_sel[e*SEL_W +: SEL_W] = SEL_W'(p);
        end
      end
    end
  end

endmodule

// File: rtl/rob_queue.sv
// Reorder buffer: in-order dispatch, multi-port out-of-order writeback,
// in-order commit, partial squash by tag and full flush on branch mispredict.
module rob_queue
  import rob_queue_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PC_W   = DEF_PC_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RF_LOG = DEF_RF_LOG,
  parameter int NUM_WB = DEF_NUM_WB,
  parameter int TAG_W  = rob_tag_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [PC_W-1:0]          disp_pc,
  input  logic                     disp_wen,
  input  logic [RF_LOG-1:0]        disp_rd,
  input  logic                     disp_is_br,
  input  logic                     disp_pred_taken,
  output logic [TAG_W-1:0]         disp_tag,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
  input  logic [NUM_WB*DATA_W-1:0] wb_data,
  input  logic [NUM_WB-1:0]        wb_taken,
  input  logic [NUM_WB*PC_W-1:0]   wb_next_pc,
  output logic                     cm_valid,
  input  logic                     cm_ready,
  output logic [TAG_W-1:0]         cm_tag,
  output logic [PC_W-1:0]          cm_pc,
  output logic                     cm_wen,
  output logic [RF_LOG-1:0]        cm_rd,
  output logic [DATA_W-1:0]        cm_data,
  output logic [PC_W-1:0]          cm_next_pc,
  output logic                     cm_squash,
  input  logic                     sq_valid,
  input  logic [TAG_W-1:0]         sq_tag,
  output logic [TAG_W:0]           count
);

  localparam int         SEL_W   = rob_sel_w(NUM_WB);
  localparam logic [TAG_W:0] PTR_ONE = (TAG_W+1)'(1);

  rob_state_t          r_state [DEPTH];
  logic [PC_W-1:0]     r_pc    [DEPTH];
  logic                r_wen   [DEPTH];
  logic [RF_LOG-1:0]   r_rd    [DEPTH];
  logic                r_is_br [DEPTH];
  logic                r_pred  [DEPTH];
  logic [DATA_W-1:0]   r_data  [DEPTH];
  logic                r_taken [DEPTH];
  logic [PC_W-1:0]     r_npc   [DEPTH];
  logic [TAG_W:0]      r_head;
  logic [TAG_W:0]      r_tail;

  logic [TAG_W-1:0]    w_head_idx;
  logic                w_full;
  logic                w_disp_fire;
  logic                w_cm_fire;
  logic                w_cm_flush;
  logic [TAG_W-1:0]    w_sq_off;
  logic                w_sq_fire;
  logic [DEPTH-1:0]    w_wb_hit;
  logic [DEPTH*SEL_W-1:0] w_wb_sel;
  logic [DEPTH-1:0]    w_kill;
  logic [DEPTH-1:0]    w_wb_upd;
  logic [DATA_W-1:0]   w_sel_data  [DEPTH];
  logic                w_sel_taken [DEPTH];
  logic [PC_W-1:0]     w_sel_npc   [DEPTH];

  assign w_head_idx  = r_head[TAG_W-1:0];
  assign count       = r_tail - r_head;
  assign w_full      = (count == (TAG_W+1)'(DEPTH));
  assign disp_tag    = r_tail[TAG_W-1:0];

  assign cm_valid    = (r_state[w_head_idx] == ST_DONE);
  assign cm_squash   = cm_valid && r_is_br[w_head_idx] &&
                       (r_pred[w_head_idx] != r_taken[w_head_idx]);
  assign cm_tag      = w_head_idx;
  assign cm_pc       = r_pc[w_head_idx];
  assign cm_wen      = r_wen[w_head_idx];
  assign cm_rd       = r_rd[w_head_idx];
  assign cm_data     = r_data[w_head_idx];
  assign cm_next_pc  = r_npc[w_head_idx];

  assign disp_ready  = !w_full && !sq_valid && !(cm_valid && cm_squash);
  assign w_disp_fire = disp_valid && disp_ready;
  assign w_cm_fire   = cm_valid && cm_ready;
  assign w_cm_flush  = w_cm_fire && cm_squash;

  // Squash target is live when its distance from head is below the occupancy.
  assign w_sq_off    = sq_tag - w_head_idx;
  assign w_sq_fire   = sq_valid && ({1'b0, w_sq_off} < count) && !w_cm_flush;

  rob_wb_arbiter #(
    .DEPTH  (DEPTH),
    .NUM_WB (NUM_WB),
    .TAG_W  (TAG_W),
    .SEL_W  (SEL_W)
  ) u_wb_arb (
    .i_wb_valid (wb_valid),
    .i_wb_tag   (wb_tag),
    .o_hit      (w_wb_hit),
    .o_sel      (w_wb_sel)
  );

  always_comb begin
    w_kill   = '0;
    w_wb_upd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_kill[i]      = w_sq_fire && ((TAG_W'(i) - w_head_idx) > w_sq_off);
      w_wb_upd[i]    = w_wb_hit[i] && (r_state[i] == ST_PENDING) &&
                       !w_kill[i] && !w_cm_flush;
      w_sel_data[i]  = '0;
      w_sel_taken[i] = 1'b0;
      w_sel_npc[i]   = '0;
      for (int p = 0; p < NUM_WB; p++) begin
        if (w_wb_sel[i*SEL_W +: SEL_W] == SEL_W'(p)) begin
          w_sel_data[i]  = wb_data[p*DATA_W +: DATA_W];
          w_sel_taken[i] = wb_taken[p];
          w_sel_npc[i]   = wb_next_pc[p*PC_W +: PC_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      for (int i = 0; i < DEPTH; i++) r_state[i] <= ST_IDLE;
    end else begin
      if (w_cm_fire) r_head <= r_head + PTR_ONE;
      if (w_cm_flush) begin
        r_tail <= r_head + PTR_ONE;
        for (int i = 0; i < DEPTH; i++) r_state[i] <= ST_IDLE;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_kill[i])        r_state[i] <= ST_IDLE;
          else if (w_wb_upd[i]) r_state[i] <= ST_DONE;
        end
        if (w_cm_fire) r_state[w_head_idx] <= ST_IDLE;
        if (w_sq_fire) begin
          r_tail <= r_head + {1'b0, w_sq_off} + PTR_ONE;
        end else if (w_disp_fire) begin
          r_tail            <= r_tail + PTR_ONE;
          r_state[disp_tag] <= ST_PENDING;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_disp_fire) begin
      r_pc[disp_tag]    <= disp_pc;
      r_wen[disp_tag]   <= disp_wen;
      r_rd[disp_tag]    <= disp_rd;
      r_is_br[disp_tag] <= disp_is_br;
      r_pred[disp_tag]  <= disp_pred_taken;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wb_upd[i]) begin
        r_data[i]  <= w_sel_data[i];
        r_taken[i] <= w_sel_taken[i];
        r_npc[i]   <= w_sel_npc[i];
      end
    end
  end

endmodule

// File: tb/tb_rob_queue.sv
// Directed bench for rob_queue with a queue-based reference model checked on
// every falling edge, plus hand-computed expectations per scenario.
module tb_rob_queue;

  localparam int DEPTH  = 8;
  localparam int TAG_W  = 3;
  localparam int PC_W   = 4;
  localparam int DATA_W = 8;
  localparam int RF_LOG = 2;
  localparam int NUM_WB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic disp_valid = 1'b0, disp_ready;
  logic [PC_W-1:0] disp_pc = '0;
  logic disp_wen = 1'b0;
  logic [RF_LOG-1:0] disp_rd = '0;
  logic disp_is_br = 1'b0, disp_pred_taken = 1'b0;
  logic [TAG_W-1:0] disp_tag;
  logic [NUM_WB-1:0] wb_valid = '0;
  logic [NUM_WB*TAG_W-1:0] wb_tag = '0;
  logic [NUM_WB*DATA_W-1:0] wb_data = '0;
  logic [NUM_WB-1:0] wb_taken = '0;
  logic [NUM_WB*PC_W-1:0] wb_next_pc = '0;
  logic cm_valid, cm_ready = 1'b0;
  logic [TAG_W-1:0] cm_tag;
  logic [PC_W-1:0] cm_pc;
  logic cm_wen;
  logic [RF_LOG-1:0] cm_rd;
  logic [DATA_W-1:0] cm_data;
  logic [PC_W-1:0] cm_next_pc;
  logic cm_squash;
  logic sq_valid = 1'b0;
  logic [TAG_W-1:0] sq_tag = '0;
  logic [TAG_W:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  rob_queue #(
    .DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DATA_W), .RF_LOG(RF_LOG), .NUM_WB(NUM_WB)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pc(disp_pc),
    .disp_wen(disp_wen), .disp_rd(disp_rd), .disp_is_br(disp_is_br),
    .disp_pred_taken(disp_pred_taken), .disp_tag(disp_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .wb_taken(wb_taken), .wb_next_pc(wb_next_pc),
    .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_tag(cm_tag), .cm_pc(cm_pc),
    .cm_wen(cm_wen), .cm_rd(cm_rd), .cm_data(cm_data), .cm_next_pc(cm_next_pc),
    .cm_squash(cm_squash), .sq_valid(sq_valid), .sq_tag(sq_tag), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the ROB as an ordered list of live entries.
  typedef struct {
    int pc; int wen; int rd; int is_br; int pred;
    int done; int data; int taken; int npc;
  } ent_t;

  ent_t q[$];
  int   m_head = 0;

  always @(posedge clk or posedge rst) begin : model
    int sz, off, tag, pos;
    bit cmv, cms, dfire, cfire, live;
    ent_t e;
    if (rst) begin
      q.delete();
      m_head = 0;
    end else begin
      sz    = q.size();
      cmv   = (sz > 0) && (q[0].done != 0);
      cms   = cmv && (q[0].is_br != 0) && (q[0].pred != q[0].taken);
      dfire = disp_valid && (sz < DEPTH) && !sq_valid && !(cmv && cms);
      cfire = cmv && cm_ready;
      off   = (int'(sq_tag) - m_head) & (DEPTH - 1);
      live  = off < sz;
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid[p]) begin
          tag = int'(wb_tag[p*TAG_W +: TAG_W]);
          pos = (tag - m_head) & (DEPTH - 1);
          if (pos < sz && q[pos].done == 0) begin
            e       = q[pos];
            e.done  = 1;
            e.data  = int'(wb_data[p*DATA_W +: DATA_W]);
            e.taken = int'(wb_taken[p]);
            e.npc   = int'(wb_next_pc[p*PC_W +: PC_W]);
            q[pos]  = e;
          end
        end
      end
      if (cfire && cms) begin
        q.delete();
        m_head = (m_head + 1) % DEPTH;
      end else begin
        if (sq_valid && live)
          while (q.size() > off + 1) void'(q.pop_back());
        if (cfire) begin
          void'(q.pop_front());
          m_head = (m_head + 1) % DEPTH;
        end
        if (dfire) begin
          e = '{pc: int'(disp_pc), wen: int'(disp_wen), rd: int'(disp_rd),
                is_br: int'(disp_is_br), pred: int'(disp_pred_taken),
                done: 0, data: 0, taken: 0, npc: 0};
          q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int sz;
    bit cmv, cms;
    if (!rst) begin
      sz  = q.size();
      cmv = (sz > 0) && (q[0].done != 0);
      cms = cmv && (q[0].is_br != 0) && (q[0].pred != q[0].taken);
      chk("count", int'(count), sz);
      chk("disp_tag", int'(disp_tag), (m_head + sz) % DEPTH);
      chk("disp_ready", int'(disp_ready), int'(sz < DEPTH && !sq_valid && !(cmv && cms)));
      chk("cm_valid", int'(cm_valid), int'(cmv));
      chk("cm_squash", int'(cm_squash), int'(cms));
      if (cmv) begin
        chk("cm_tag", int'(cm_tag), m_head);
        chk("cm_pc", int'(cm_pc), q[0].pc);
        chk("cm_wen", int'(cm_wen), q[0].wen);
        chk("cm_rd", int'(cm_rd), q[0].rd);
        chk("cm_data", int'(cm_data), q[0].data);
        chk("cm_next_pc", int'(cm_next_pc), q[0].npc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    disp_valid = 1'b0;
    wb_valid   = '0;
    sq_valid   = 1'b0;
  endtask

  task automatic disp(input int pc, input int rd, input int is_br, input int pred);
    disp_valid      = 1'b1;
    disp_pc         = PC_W'(pc);
    disp_wen        = 1'b1;
    disp_rd         = RF_LOG'(rd);
    disp_is_br      = is_br[0];
    disp_pred_taken = pred[0];
  endtask

  task automatic wb(input int p, input int tag, input int data, input int taken, input int npc);
    wb_valid[p]                   = 1'b1;
    wb_tag[p*TAG_W +: TAG_W]      = TAG_W'(tag);
    wb_data[p*DATA_W +: DATA_W]   = DATA_W'(data);
    wb_taken[p]                   = taken[0];
    wb_next_pc[p*PC_W +: PC_W]    = PC_W'(npc);
  endtask

  task automatic do_reset();
    cm_ready = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Commit n entries with ready held high, expecting consecutive tags.
  task automatic drain(input string name, input int first_tag, input int n);
    int k = 0;
    cm_ready = 1'b1;
    for (int c = 0; c < 40 && k < n; c++) begin
      if (cm_valid) begin
        chk({name, "_tag"}, int'(cm_tag), (first_tag + k) % DEPTH);
        k++;
      end
      step();
    end
    chk({name, "_count"}, k, n);
    cm_ready = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int seen;
    // Reset state
    #12;
    chk("rst_count", int'(count), 0);
    chk("rst_disp_ready", int'(disp_ready), 1);
    chk("rst_cm_valid", int'(cm_valid), 0);
    chk("rst_cm_squash", int'(cm_squash), 0);
    chk("rst_disp_tag", int'(disp_tag), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill to capacity; the ninth dispatch must be refused
    for (int i = 0; i < 9; i++) begin
      disp(i, i % 4, 0, 0);
      step();
    end
    chk("full_count", int'(count), 8);
    chk("full_ready", int'(disp_ready), 0);
    for (int t = 0; t < 8; t += 2) begin
      wb(0, t, 16 + t, 0, t);
      wb(1, t + 1, 17 + t, 0, t + 1);
      step();
    end
    chk("full_head_data", int'(cm_data), 16);
    drain("fill", 0, 8);

    // Out-of-order writeback, in-order commit (head pointer now at tag 0 again)
    for (int i = 0; i < 4; i++) begin
      disp(i + 4, i, 0, 0);
      step();
    end
    cm_ready = 1'b1;
    wb(1, 3, 8'h33, 0, 1);
    wb(0, 1, 8'h11, 0, 2);
    step();
    chk("ooo_no_cm", int'(cm_valid), 0);
    wb(1, 2, 8'h22, 0, 3);
    wb(0, 0, 8'h00, 0, 4);
    chk("ooo_no_bypass", int'(cm_valid), 0);
    step();
    chk("ooo_cm_rise", int'(cm_valid), 1);
    drain("ooo", 0, 4);

    // Two ports writing the same tag: port 0 wins
    disp(5, 1, 0, 0);
    step();
    wb(0, 4, 8'hAA, 0, 5);
    wb(1, 4, 8'hBB, 0, 6);
    step();
    chk("dual_cm_valid", int'(cm_valid), 1);
    chk("dual_data", int'(cm_data), 8'hAA);
    chk("dual_npc", int'(cm_next_pc), 5);
    drain("dual", 4, 1);

    // Mispredicted branch at tag 2 flushes the ROB at commit
    do_reset();
    for (int i = 0; i < 6; i++) begin
      disp(i, i % 4, (i == 2) ? 1 : 0, 0);
      step();
    end
    wb(0, 0, 1, 0, 1);
    wb(1, 1, 2, 0, 2);
    step();
    wb(0, 2, 3, 1, 9);
    wb(1, 3, 4, 0, 4);
    step();
    cm_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !(cm_valid && cm_squash); c++) step();
    chk("br_squash", int'(cm_squash), 1);
    chk("br_tag", int'(cm_tag), 2);
    chk("br_next_pc", int'(cm_next_pc), 9);
    disp(7, 0, 0, 0);
    chk("br_disp_refused", int'(disp_ready), 0);
    step();
    cm_ready = 1'b0;
    chk("br_count", int'(count), 0);
    chk("br_cm_valid", int'(cm_valid), 0);
    chk("br_disp_tag", int'(disp_tag), 3);
    wb(0, 4, 5, 0, 5);
    step();
    chk("br_stale_wb", int'(count), 0);

    // Partial squash: keep tags 0..2 of six
    do_reset();
    for (int i = 0; i < 6; i++) begin
      disp(i, i % 4, 0, 0);
      step();
    end
    sq_valid = 1'b1;
    sq_tag   = 3'd2;
    wb(0, 4, 8'h44, 0, 1);
    wb(1, 1, 8'h55, 0, 2);
    disp(9, 0, 0, 0);
    step();
    chk("sq_count", int'(count), 3);
    chk("sq_disp_tag", int'(disp_tag), 3);
    sq_valid = 1'b1;
    sq_tag   = 3'd6;
    step();
    chk("sq_dead_tag", int'(count), 3);
    wb(0, 0, 8'h0A, 0, 3);
    wb(1, 2, 8'h2A, 0, 4);
    step();
    chk("sq_head_data", int'(cm_data), 8'h0A);
    cm_ready = 1'b1;
    sq_valid = 1'b1;
    sq_tag   = 3'd0;
    step();
    cm_ready = 1'b0;
    chk("sq_at_head_count", int'(count), 0);
    chk("sq_at_head_disp_tag", int'(disp_tag), 1);

    // Streaming dispatch/commit pairs across the tag wrap
    do_reset();
    cm_ready = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) begin
        chk("wrap_disp_tag", int'(disp_tag), i % DEPTH);
        disp(i % 16, i % 4, 0, 0);
      end
      if (i > 0) wb(0, (i - 1) % DEPTH, i, 0, i % 16);
      step();
    end
    step();
    chk("wrap_empty", int'(count), 0);
    cm_ready = 1'b0;
    disp(1, 1, 0, 0);
    step();
    disp(2, 2, 0, 0);
    step();
    wb(0, 4, 8'h77, 0, 7);
    wb(1, 5, 8'h78, 0, 8);
    step();
    chk("pre_rst_count", int'(count), 2);
    chk("pre_rst_cm_valid", int'(cm_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_cm_valid", int'(cm_valid), 0);
    chk("async_rst_disp_ready", int'(disp_ready), 1);
    chk("async_rst_disp_tag", int'(disp_tag), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
